// File: rtl/powlib_busmem.sv
// Bus write sink: commits in-window words from a crossbar lane into a local
// register array, counts dropped words, and serves 1-cycle reads with forwarding.
module powlib_busmem #(
    parameter int unsigned        B_AW   = 2,
    parameter int unsigned        B_DW   = 4,
    parameter logic [B_AW-1:0]    B_BASE = '0,
    parameter int unsigned        B_SIZE = 4,
    parameter int unsigned        ECW    = 8,
    parameter string              ID     = "BUSMEM",
    parameter bit                 EDBG   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [B_DW-1:0] wrdata,
    input  logic [B_AW-1:0] wraddr,
    input  logic            wrvld,
    output logic            wrrdy,
    input  logic            clr,
    output logic            busy,
    input  logic [B_AW-1:0] rdaddr,
    input  logic            rdreq,
    output logic [B_DW-1:0] rddata,
    output logic            rdvld,
    output logic            rderr,
    output logic [ECW-1:0]  errcnt
);

    localparam int unsigned   IW       = (B_SIZE > 1) ? $clog2(B_SIZE) : 1;
    localparam logic [B_AW:0] WIN_LO   = {1'b0, B_BASE};
    localparam logic [B_AW:0] WIN_SIZE = (B_AW+1)'(B_SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(B_SIZE - 1);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

    // Offset from the window base in one extra bit: addresses below the base
    // wrap to >= 2**B_AW, so a single "< size" compare tests both bounds.
    function automatic logic [B_AW:0] win_off(input logic [B_AW-1:0] a);
        return {1'b0, a} - WIN_LO;
    endfunction

    logic [B_DW-1:0] mem [B_SIZE];

    state_t          state_reg;
    logic [IW-1:0]   init_idx_reg;
    logic            s1_vld_reg;
    logic            s1_win_reg;
    logic [IW-1:0]   s1_idx_reg;
    logic [B_DW-1:0] s1_data_reg;
    logic [ECW-1:0]  errcnt_reg;
    logic            rdvld_reg;
    logic            rderr_reg;
    logic [B_DW-1:0] rddata_reg;

    logic [B_AW:0]   wr_off;
    logic [B_AW:0]   rd_off;
    logic            wr_in_win;
    logic            rd_in_win;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic            run;
    logic            wr_fire;
    logic            rd_fire;
    logic            rd_fwd;

    assign wr_off    = win_off(wraddr);
    assign rd_off    = win_off(rdaddr);
    assign wr_in_win = (wr_off < WIN_SIZE);
    assign rd_in_win = (rd_off < WIN_SIZE);
    assign wr_idx    = IW'(wr_off);
    assign rd_idx    = IW'(rd_off);

    assign run     = (state_reg == ST_RUN);
    assign wr_fire = wrvld && run;
    assign rd_fire = rdreq && run;
    // The word in s1 commits on the same edge the read samples memory.
    assign rd_fwd  = s1_vld_reg && s1_win_reg && (s1_idx_reg == rd_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_INIT;
            init_idx_reg <= '0;
            s1_vld_reg   <= 1'b0;
            s1_win_reg   <= 1'b0;
            s1_idx_reg   <= '0;
            s1_data_reg  <= '0;
            errcnt_reg   <= '0;
            rdvld_reg    <= 1'b0;
            rderr_reg    <= 1'b0;
            rddata_reg   <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (clr) begin
                        init_idx_reg <= '0;
                    end else if (init_idx_reg == LAST_IDX) begin
                        state_reg <= ST_RUN;
                    end else begin
                        init_idx_reg <= init_idx_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_reg    <= ST_INIT;
                    init_idx_reg <= '0;
                end
                default: state_reg <= ST_INIT;
            endcase

            s1_vld_reg <= wr_fire;
            if (wr_fire) begin
                s1_win_reg  <= wr_in_win;
                s1_idx_reg  <= wr_idx;
                s1_data_reg <= wrdata;
            end

            if (s1_vld_reg && !s1_win_reg && (errcnt_reg != '1)) begin
                errcnt_reg <= errcnt_reg + 1'b1;
            end

            rdvld_reg <= rd_fire;
            if (rd_fire) begin
                rderr_reg <= !rd_in_win;
                if (!rd_in_win) begin
                    rddata_reg <= '0;
                end else if (rd_fwd) begin
                    rddata_reg <= s1_data_reg;
                end else begin
                    rddata_reg <= mem[rd_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == ST_INIT) begin
            mem[init_idx_reg] <= '0;
        end else if (s1_vld_reg && s1_win_reg) begin
            mem[s1_idx_reg] <= s1_data_reg;
        end
    end

    assign wrrdy  = run;
    assign busy   = !run;
    assign rdvld  = rdvld_reg;
    assign rderr  = rderr_reg;
    assign rddata = rddata_reg;
    assign errcnt = errcnt_reg;

endmodule
